// File: rtl/axil_reg_bridge_if.sv
// AXI4-Lite channel bundle between the PS interconnect (master) and the register bridge (slave).
interface axil_reg_bridge_if #(
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave driving the simple register bus: one reg_wr strobe per write, one reg_rd
// strobe per read, with reads held off while a write in the same or previous cycle is landing.
module axil_reg_bridge #(
   parameter int ADDR_W     = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic              CLK,
   input  logic              RST_N,
   axil_reg_bridge_if.slave  s_axi,
   output logic              reg_wr,
   output logic [ADDR_W-1:0] reg_waddr,
   output logic [31:0]       reg_wdata,
   output logic              reg_rd,
   output logic [ADDR_W-1:0] reg_raddr,
   input  logic [31:0]       reg_rdata
);

   localparam logic [ADDR_W-1:0] ADDR_MASK   = {{(ADDR_W-2){1'b1}}, 2'b00};
   localparam logic [2:0]        RD_CNT_INIT = 3'(RD_LATENCY - 1);

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_STROBE = 2'd1,
      W_RESP   = 2'd2
   } w_state_t;

   typedef enum logic [1:0] {
      R_IDLE   = 2'd0,
      R_STROBE = 2'd1,
      R_WAIT   = 2'd2,
      R_RESP   = 2'd3
   } r_state_t;

   // The register file has no byte enables, so only all-or-nothing strobes are OKAY.
   function automatic logic [1:0] strb_resp(input logic [3:0] strb);
      logic [1:0] resp;
      case (strb)
         4'hF, 4'h0: resp = 2'b00;
         default:    resp = 2'b10;
      endcase
      return resp;
   endfunction

   w_state_t          w_state_r, w_state_s;
   r_state_t          r_state_r, r_state_s;
   logic              w_accept_s, ar_accept_s;
   logic [3:0]        w_strb_r;
   logic              reg_wr_r, reg_rd_r;
   logic [ADDR_W-1:0] reg_waddr_r, reg_raddr_r;
   logic [31:0]       reg_wdata_r, rdata_r;
   logic [1:0]        bresp_r;
   logic              bvalid_r, rvalid_r;
   logic [2:0]        rd_cnt_r;

   // Write channel next-state: AW and W are only taken together.
   always_comb begin
      w_state_s  = w_state_r;
      w_accept_s = 1'b0;
      case (w_state_r)
         W_IDLE: begin
            if (s_axi.awvalid && s_axi.wvalid) begin
               w_accept_s = 1'b1;
               w_state_s  = W_STROBE;
            end else begin
               w_state_s  = W_IDLE;
            end
         end
         W_STROBE: w_state_s = W_RESP;
         W_RESP: begin
            if (s_axi.bready) begin
               w_state_s = W_IDLE;
            end else begin
               w_state_s = W_RESP;
            end
         end
         default: w_state_s = W_IDLE;
      endcase
   end

   // Read channel next-state; acceptance waits out any write landing now or next cycle.
   always_comb begin
      r_state_s   = r_state_r;
      ar_accept_s = 1'b0;
      case (r_state_r)
         R_IDLE: begin
            if (s_axi.arvalid && !w_accept_s && (w_state_r != W_STROBE)) begin
               ar_accept_s = 1'b1;
               r_state_s   = R_STROBE;
            end else begin
               r_state_s   = R_IDLE;
            end
         end
         R_STROBE: r_state_s = R_WAIT;
         R_WAIT: begin
            if (rd_cnt_r == 3'd0) begin
               r_state_s = R_RESP;
            end else begin
               r_state_s = R_WAIT;
            end
         end
         R_RESP: begin
            if (s_axi.rready) begin
               r_state_s = R_IDLE;
            end else begin
               r_state_s = R_RESP;
            end
         end
         default: r_state_s = R_IDLE;
      endcase
   end

   // Write channel state, strobe and response registers.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         w_state_r   <= W_IDLE;
         w_strb_r    <= 4'h0;
         reg_wr_r    <= 1'b0;
         reg_waddr_r <= '0;
         reg_wdata_r <= 32'h0;
         bresp_r     <= 2'b00;
         bvalid_r    <= 1'b0;
      end else begin
         w_state_r <= w_state_s;
         reg_wr_r  <= w_accept_s && (s_axi.wstrb == 4'hF);
         if (w_accept_s) begin
            w_strb_r <= s_axi.wstrb;
            if (s_axi.wstrb == 4'hF) begin
               reg_waddr_r <= s_axi.awaddr & ADDR_MASK;
               reg_wdata_r <= s_axi.wdata;
            end
         end
         if (w_state_r == W_STROBE) begin
            bresp_r <= strb_resp(w_strb_r);
         end
         bvalid_r <= (w_state_s == W_RESP);
      end
   end

   // Read channel state, latency counter and captured read data.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state_r   <= R_IDLE;
         reg_rd_r    <= 1'b0;
         reg_raddr_r <= '0;
         rd_cnt_r    <= 3'd0;
         rdata_r     <= 32'h0;
         rvalid_r    <= 1'b0;
      end else begin
         r_state_r <= r_state_s;
         reg_rd_r  <= ar_accept_s;
         if (ar_accept_s) begin
            reg_raddr_r <= s_axi.araddr & ADDR_MASK;
         end
         if (r_state_r == R_STROBE) begin
            rd_cnt_r <= RD_CNT_INIT;
         end else if ((r_state_r == R_WAIT) && (rd_cnt_r != 3'd0)) begin
            rd_cnt_r <= rd_cnt_r - 3'd1;
         end
         if ((r_state_r == R_WAIT) && (rd_cnt_r == 3'd0)) begin
            rdata_r <= reg_rdata;
         end
         rvalid_r <= (r_state_s == R_RESP);
      end
   end

   // Strobes and readies are masked by reset so a transaction caught by reset never fires.
   assign s_axi.awready = w_accept_s & RST_N;
   assign s_axi.wready  = w_accept_s & RST_N;
   assign s_axi.arready = ar_accept_s & RST_N;
   assign s_axi.bresp   = bresp_r;
   assign s_axi.bvalid  = bvalid_r;
   assign s_axi.rdata   = rdata_r;
   assign s_axi.rresp   = 2'b00;
   assign s_axi.rvalid  = rvalid_r;
   assign reg_wr        = reg_wr_r & RST_N;
   assign reg_rd        = reg_rd_r & RST_N;
   assign reg_waddr     = reg_waddr_r;
   assign reg_wdata     = reg_wdata_r;
   assign reg_raddr     = reg_raddr_r;

endmodule
